// File: rtl/data_mem_port.sv
// data_mem_port
//
// Data-side memory port that sits behind the Memory1 stage. Stores are
// posted into a small circular write buffer and complete at once. Loads are
// answered from the youngest matching buffer entry when there is one.
// Otherwise the load waits for the buffer to drain to memory and then reads
// over a req/ack bus.
//
// Ports
//   Clock, Reset          rising-edge clock, synchronous active-low reset
//   DataAddr, DataOut     request address / store data
//   ReadData, WriteData   one-cycle load / store request strobes
//   DataIn, DataDone      load result (held) / one-cycle completion pulse
//   Busy                  a request is outstanding; new requests are dropped
//   Overrun               sticky flag: a request arrived while Busy was high
//   WbCount               write-buffer occupancy, 0..WB_DEPTH
//   MemReq, MemWe         bus request / write enable
//   MemAddr, MemWData     bus address / write data
//   MemAck, MemRData      bus completion / read data
//
// Handshakes
//   Processor side: a request is taken on any edge where
//   (ReadData | WriteData) is high and Busy is low. Completion is signalled
//   by exactly one DataDone pulse per accepted request.
//   Bus side: MemReq acts as valid and MemAck as ready. Address, direction
//   and write data stay stable from the rise of MemReq through the edge that
//   samples MemAck. MemReq then drops on that same edge and stays low for at
//   least one cycle.

module data_mem_port #(
  parameter int WORD_SIZE = 16,
  parameter int WB_DEPTH  = 4
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic [WORD_SIZE-1:0]       DataAddr,
  input  logic [WORD_SIZE-1:0]       DataOut,
  input  logic                       ReadData,
  input  logic                       WriteData,
  output logic [WORD_SIZE-1:0]       DataIn,
  output logic                       DataDone,
  output logic                       Busy,
  output logic                       Overrun,
  output logic [$clog2(WB_DEPTH):0]  WbCount,
  output logic                       MemReq,
  output logic                       MemWe,
  output logic [WORD_SIZE-1:0]       MemAddr,
  output logic [WORD_SIZE-1:0]       MemWData,
  input  logic                       MemAck,
  input  logic [WORD_SIZE-1:0]       MemRData
);

  localparam int PW = $clog2(WB_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {B_IDLE, B_WRITE, B_READ} bus_state_t;

  // Write buffer storage (contents need no reset; validity comes from r_count)
  logic [WORD_SIZE-1:0] r_wb_addr [WB_DEPTH];
  logic [WORD_SIZE-1:0] r_wb_data [WB_DEPTH];
  logic [PW-1:0]        r_head;
  logic [PW-1:0]        r_tail;
  logic [CW-1:0]        r_count;

  bus_state_t           r_state;
  logic                 r_mem_req;
  logic                 r_mem_we;
  logic [WORD_SIZE-1:0] r_mem_addr;
  logic [WORD_SIZE-1:0] r_mem_wdata;

  logic [WORD_SIZE-1:0] r_data_in;
  logic                 r_data_done;
  logic                 r_busy;
  logic                 r_overrun;

  // The single request that could not complete immediately
  logic                 r_pend_valid;
  logic                 r_pend_store;
  logic [WORD_SIZE-1:0] r_pend_addr;
  logic [WORD_SIZE-1:0] r_pend_data;

  logic                 w_req;
  logic                 w_accept;
  logic                 w_full;
  logic                 w_push_new;
  logic                 w_store_stall;
  logic                 w_load;
  logic                 w_push_pend;
  logic                 w_push;
  logic [WORD_SIZE-1:0] w_push_addr;
  logic [WORD_SIZE-1:0] w_push_data;
  logic                 w_pop;
  logic                 w_rd_done;
  logic                 w_match;
  logic [WORD_SIZE-1:0] w_hit_data;
  logic [PW-1:0]        w_idx;
  logic                 w_hit;
  logic                 w_miss;

  bus_state_t           w_state_nxt;
  logic                 w_req_nxt;
  logic                 w_we_nxt;
  logic [WORD_SIZE-1:0] w_addr_nxt;
  logic [WORD_SIZE-1:0] w_wdata_nxt;

  assign w_req         = ReadData | WriteData;
  assign w_accept      = w_req & ~r_busy;
  assign w_full        = (r_count == CW'(WB_DEPTH));
  assign w_push_new    = w_accept & WriteData & ~w_full;
  assign w_store_stall = w_accept & WriteData & w_full;
  assign w_load        = w_accept & ~WriteData;
  // A stalled store re-enters the buffer on the edge after the freeing pop,
  // because the full test looks at the registered count.
  assign w_push_pend   = r_pend_valid & r_pend_store & ~w_full;
  assign w_push        = w_push_new | w_push_pend;
  assign w_push_addr   = w_push_pend ? r_pend_addr : DataAddr;
  assign w_push_data   = w_push_pend ? r_pend_data : DataOut;
  assign w_pop         = (r_state == B_WRITE) & MemAck;
  assign w_rd_done     = (r_state == B_READ) & MemAck;

  // Walk the buffer from oldest to youngest. The last match wins, which
  // gives the youngest matching entry.
  always_comb begin
    w_match    = 1'b0;
    w_hit_data = '0;
    w_idx      = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      w_idx = r_head + PW'(i);
      if ((CW'(i) < r_count) && (r_wb_addr[w_idx] == DataAddr)) begin
        w_match    = 1'b1;
        w_hit_data = r_wb_data[w_idx];
      end
    end
  end

  assign w_hit  = w_load & w_match;
  assign w_miss = w_load & ~w_match;

  // Bus FSM next state and next bus outputs
  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_mem_req;
    w_we_nxt    = r_mem_we;
    w_addr_nxt  = r_mem_addr;
    w_wdata_nxt = r_mem_wdata;
    case (r_state)
      B_IDLE: begin
        if (r_count != '0) begin
          w_state_nxt = B_WRITE;
          w_req_nxt   = 1'b1;
          w_we_nxt    = 1'b1;
          w_addr_nxt  = r_wb_addr[r_head];
          w_wdata_nxt = r_wb_data[r_head];
        end else if (w_push) begin
          // Empty buffer: the entry being pushed now becomes the head.
          // Start writing it straight away.
          w_state_nxt = B_WRITE;
          w_req_nxt   = 1'b1;
          w_we_nxt    = 1'b1;
          w_addr_nxt  = w_push_addr;
          w_wdata_nxt = w_push_data;
        end else if (r_pend_valid && !r_pend_store) begin
          w_state_nxt = B_READ;
          w_req_nxt   = 1'b1;
          w_we_nxt    = 1'b0;
          w_addr_nxt  = r_pend_addr;
        end
      end
      B_WRITE: begin
        if (MemAck) begin
          w_state_nxt = B_IDLE;
          w_req_nxt   = 1'b0;
        end
      end
      B_READ: begin
        if (MemAck) begin
          w_state_nxt = B_IDLE;
          w_req_nxt   = 1'b0;
        end
      end
      default: begin
        w_state_nxt = B_IDLE;
        w_req_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (w_push) begin
      r_wb_addr[r_tail] <= w_push_addr;
      r_wb_data[r_tail] <= w_push_data;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_state      <= B_IDLE;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_data_in    <= '0;
      r_data_done  <= 1'b0;
      r_busy       <= 1'b0;
      r_overrun    <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pend_store <= 1'b0;
      r_pend_addr  <= '0;
      r_pend_data  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_mem_req   <= w_req_nxt;
      r_mem_we    <= w_we_nxt;
      r_mem_addr  <= w_addr_nxt;
      r_mem_wdata <= w_wdata_nxt;

      if (w_push) r_tail <= r_tail + PW'(1);
      if (w_pop)  r_head <= r_head + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);

      if (w_store_stall || w_miss) begin
        r_pend_valid <= 1'b1;
        r_pend_store <= w_store_stall;
        r_pend_addr  <= DataAddr;
        r_pend_data  <= DataOut;
        r_busy       <= 1'b1;
      end else if (w_push_pend || w_rd_done) begin
        r_pend_valid <= 1'b0;
        r_busy       <= 1'b0;
      end

      r_data_done <= w_push_new | w_push_pend | w_hit | w_rd_done;
      if (w_hit)          r_data_in <= w_hit_data;
      else if (w_rd_done) r_data_in <= MemRData;

      if (w_req && r_busy) r_overrun <= 1'b1;
    end
  end

  assign DataIn   = r_data_in;
  assign DataDone = r_data_done;
  assign Busy     = r_busy;
  assign Overrun  = r_overrun;
  assign WbCount  = r_count;
  assign MemReq   = r_mem_req;
  assign MemWe    = r_mem_we;
  assign MemAddr  = r_mem_addr;
  assign MemWData = r_mem_wdata;

endmodule

// File: tb/tb_data_mem_port.sv
// tb_data_mem_port
//
// Bench for data_mem_port. An architectural model (arch) holds the value
// each address should return in program order. A bus memory (phys) is
// updated only when the bus write actually completes. The expected bus write
// order is kept in exp_q. Directed scenarios run first, then a randomized
// mix of loads and stores with random bus latency.

module tb_data_mem_port;

  localparam int W = 16;
  localparam int D = 4;

  logic         Clock = 1'b0;
  logic         Reset = 1'b0;
  logic [W-1:0] DataAddr = '0;
  logic [W-1:0] DataOut = '0;
  logic         ReadData = 1'b0;
  logic         WriteData = 1'b0;
  logic [W-1:0] DataIn;
  logic         DataDone;
  logic         Busy;
  logic         Overrun;
  logic [2:0]   WbCount;
  logic         MemReq;
  logic         MemWe;
  logic [W-1:0] MemAddr;
  logic [W-1:0] MemWData;
  logic         MemAck;
  logic [W-1:0] MemRData;

  data_mem_port #(.WORD_SIZE(W), .WB_DEPTH(D)) dut (
    .Clock(Clock), .Reset(Reset), .DataAddr(DataAddr), .DataOut(DataOut),
    .ReadData(ReadData), .WriteData(WriteData), .DataIn(DataIn),
    .DataDone(DataDone), .Busy(Busy), .Overrun(Overrun), .WbCount(WbCount),
    .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemAck(MemAck), .MemRData(MemRData)
  );

  // Clock / watchdog
  always #5 Clock = ~Clock;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish want finish");
    $fatal(1);
  end

  int errors = 0;
  int checks = 0;

  logic [W-1:0]   phys [logic [W-1:0]];
  logic [W-1:0]   arch [logic [W-1:0]];
  logic [2*W-1:0] exp_q [$];

  int rsp_en = 0;
  int rsp_rand = 0;
  int rsp_delay = 1;
  int ack_budget = 1000000;
  int rd_cnt = 0;

  function automatic logic [W-1:0] mem_init(logic [W-1:0] a);
    return a ^ 16'hA5A5;
  endfunction

  function logic [W-1:0] exp_load(logic [W-1:0] a);
    if (arch.exists(a)) return arch[a];
    return mem_init(a);
  endfunction

  // Bus responder and bus-side scoreboard
  initial begin : responder
    int rcnt;
    int rdelay;
    logic [W-1:0] s_addr, s_wdata;
    logic s_we;
    logic [2*W-1:0] e;
    MemAck = 1'b0;
    MemRData = '0;
    rcnt = 0;
    rdelay = 1;
    forever begin
      @(posedge Clock);
      #1;
      if (MemAck) begin
        MemAck = 1'b0;
        rcnt = 0;
        checks++;
        if (MemReq !== 1'b0) begin
          errors++;
          $display("FAIL bus_drop: MemReq got %b want 0 after ack", MemReq);
        end
      end else if (MemReq === 1'b1 && Reset === 1'b1) begin
        if (rcnt == 0) begin
          s_addr = MemAddr; s_we = MemWe; s_wdata = MemWData;
          rdelay = (rsp_rand != 0) ? int'($urandom_range(1, 4)) : rsp_delay;
          if (!MemWe) begin
            checks++;
            if (WbCount !== 3'd0) begin
              errors++;
              $display("FAIL rd_order: WbCount got %0d want 0 at read start", WbCount);
            end
          end
        end else begin
          checks++;
          if ({MemAddr, MemWe, MemWData} !== {s_addr, s_we, s_wdata}) begin
            errors++;
            $display("FAIL bus_stable: got %h/%b/%h want %h/%b/%h",
                     MemAddr, MemWe, MemWData, s_addr, s_we, s_wdata);
          end
        end
        rcnt++;
        if (rsp_en != 0 && ack_budget > 0 && rcnt >= rdelay) begin
          ack_budget--;
          MemAck = 1'b1;
          if (MemWe) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL wr_order: got write %h=%h want none", MemAddr, MemWData);
            end else begin
              e = exp_q.pop_front();
              if ({MemAddr, MemWData} !== e) begin
                errors++;
                $display("FAIL wr_order: got %h=%h want %h=%h",
                         MemAddr, MemWData, e[2*W-1:W], e[W-1:0]);
              end
            end
            phys[MemAddr] = MemWData;
          end else begin
            MemRData = phys.exists(MemAddr) ? phys[MemAddr] : mem_init(MemAddr);
            rd_cnt++;
          end
        end
      end else begin
        rcnt = 0;
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_store(input logic [W-1:0] a, input logic [W-1:0] d);
    if (Busy === 1'b0) begin
      arch[a] = d;
      exp_q.push_back({a, d});
    end
    DataAddr = a; DataOut = d; WriteData = 1'b1;
    step();
    WriteData = 1'b0;
  endtask

  task automatic do_load(input logic [W-1:0] a);
    DataAddr = a; ReadData = 1'b1;
    step();
    ReadData = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (DataDone === 1'b1) begin
        ok = 1'b1;
        return;
      end
      step();
    end
  endtask

  task automatic wait_drain(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (WbCount === 3'd0 && MemReq === 1'b0 && Busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_drain: got WbCount=%0d MemReq=%b want 0/0", name, WbCount, MemReq);
    end
  endtask

  // Scenarios
  task automatic test_reset();
    Reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ReadData = 1'($urandom); WriteData = 1'($urandom);
      DataAddr = 16'($urandom); DataOut = 16'($urandom);
      step();
      checks++;
      if ({DataIn, DataDone, Busy, Overrun, WbCount, MemReq, MemWe, MemAddr, MemWData} !== '0) begin
        errors++;
        $display("FAIL reset_outs: got DataIn=%h Done=%b Busy=%b Ovr=%b Wb=%0d Req=%b want all 0",
                 DataIn, DataDone, Busy, Overrun, WbCount, MemReq);
      end
    end
    ReadData = 1'b0; WriteData = 1'b0;
    Reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (MemReq !== 1'b0 || DataDone !== 1'b0) begin
        errors++;
        $display("FAIL idle_req: got MemReq=%b Done=%b want 0/0", MemReq, DataDone);
      end
    end
  endtask

  task automatic test_store_drain();
    rsp_en = 1; rsp_rand = 0; rsp_delay = 2;
    do_store(16'h0010, 16'hBEEF);
    checks++;
    if ({DataDone, Busy, MemReq, MemWe, MemAddr, MemWData, WbCount} !==
        {1'b1, 1'b0, 1'b1, 1'b1, 16'h0010, 16'hBEEF, 3'd1}) begin
      errors++;
      $display("FAIL st_issue: got Done=%b Busy=%b Req=%b We=%b %h=%h Wb=%0d want 1 0 1 1 0010=beef 1",
               DataDone, Busy, MemReq, MemWe, MemAddr, MemWData, WbCount);
    end
    step();
    checks++;
    if ({DataDone, MemReq, WbCount} !== {1'b0, 1'b1, 3'd1}) begin
      errors++;
      $display("FAIL st_wait: got Done=%b Req=%b Wb=%0d want 0 1 1", DataDone, MemReq, WbCount);
    end
    step();
    checks++;
    if ({MemReq, WbCount} !== {1'b0, 3'd0}) begin
      errors++;
      $display("FAIL st_pop: got Req=%b Wb=%0d want 0 0", MemReq, WbCount);
    end
    wait_drain("store");
  endtask

  task automatic test_forward();
    int r;
    rsp_en = 0;
    do_store(16'h0020, 16'h1111);
    do_store(16'h0020, 16'h2222);
    r = rd_cnt;
    do_load(16'h0020);
    checks++;
    if ({DataDone, Busy, DataIn} !== {1'b1, 1'b0, exp_load(16'h0020)}) begin
      errors++;
      $display("FAIL fwd_data: got Done=%b Busy=%b DataIn=%h want 1 0 %h",
               DataDone, Busy, DataIn, exp_load(16'h0020));
    end
    checks++;
    if ({WbCount, MemWe} !== {3'd2, 1'b1}) begin
      errors++;
      $display("FAIL fwd_wb: got Wb=%0d We=%b want 2 1", WbCount, MemWe);
    end
    step();
    checks++;
    if (DataDone !== 1'b0 || rd_cnt != r) begin
      errors++;
      $display("FAIL fwd_noread: got Done=%b reads=%0d want 0 %0d", DataDone, rd_cnt, r);
    end
    rsp_en = 1;
    wait_drain("fwd");
  endtask

  task automatic test_load_miss();
    int r;
    bit ok;
    rsp_en = 0;
    arch[16'h0030] = 16'h5A5A;
    phys[16'h0030] = 16'h5A5A;
    do_store(16'h0031, 16'hAAAA);
    do_store(16'h0032, 16'hBBBB);
    r = rd_cnt;
    do_load(16'h0030);
    checks++;
    if ({Busy, DataDone} !== 2'b10) begin
      errors++;
      $display("FAIL miss_busy: got Busy=%b Done=%b want 1 0", Busy, DataDone);
    end
    rsp_delay = 3; rsp_en = 1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (DataDone === 1'b1) begin ok = 1'b1; break; end
      checks++;
      if (Busy !== 1'b1) begin
        errors++;
        $display("FAIL miss_hold: got Busy=%b want 1", Busy);
      end
      step();
    end
    checks++;
    if (!ok || DataIn !== exp_load(16'h0030) || Busy !== 1'b0) begin
      errors++;
      $display("FAIL miss_data: got done=%b DataIn=%h Busy=%b want 1 %h 0",
               ok, DataIn, Busy, exp_load(16'h0030));
    end
    checks++;
    if (exp_q.size() != 0 || rd_cnt != r + 1) begin
      errors++;
      $display("FAIL miss_bus: got pending_writes=%0d reads=%0d want 0 %0d",
               exp_q.size(), rd_cnt - r, 1);
    end
    wait_drain("miss");
  endtask

  task automatic test_full();
    int pulses;
    rsp_en = 0;
    for (int i = 0; i < 4; i++) do_store(16'h0040 + 16'(i), 16'(i + 1));
    checks++;
    if ({WbCount, Busy} !== {3'd4, 1'b0}) begin
      errors++;
      $display("FAIL full_cnt: got Wb=%0d Busy=%b want 4 0", WbCount, Busy);
    end
    do_store(16'h0044, 16'h0005);
    checks++;
    if ({WbCount, Busy, DataDone} !== {3'd4, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL full_stall: got Wb=%0d Busy=%b Done=%b want 4 1 0", WbCount, Busy, DataDone);
    end
    ack_budget = 1; rsp_delay = 1; rsp_en = 1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (DataDone === 1'b1) begin
        pulses++;
        checks++;
        if ({Busy, WbCount} !== {1'b0, 3'd4}) begin
          errors++;
          $display("FAIL full_push: got Busy=%b Wb=%0d want 0 4", Busy, WbCount);
        end
      end
    end
    checks++;
    if (pulses != 1 || Busy !== 1'b0 || WbCount !== 3'd4) begin
      errors++;
      $display("FAIL full_once: got pulses=%0d Busy=%b Wb=%0d want 1 0 4", pulses, Busy, WbCount);
    end
    ack_budget = 1000000;
    wait_drain("full");
  endtask

  task automatic test_overrun();
    rsp_en = 0;
    do_store(16'h0050, 16'h0001);
    do_load(16'h0060);
    checks++;
    if ({Busy, Overrun} !== 2'b10) begin
      errors++;
      $display("FAIL ovr_pre: got Busy=%b Ovr=%b want 1 0", Busy, Overrun);
    end
    do_load(16'h0070);
    checks++;
    if ({Overrun, DataDone, Busy} !== 3'b101) begin
      errors++;
      $display("FAIL ovr_set: got Ovr=%b Done=%b Busy=%b want 1 0 1", Overrun, DataDone, Busy);
    end
    checks++;
    if (MemReq !== 1'b1) begin
      errors++;
      $display("FAIL ovr_req: got MemReq=%b want 1", MemReq);
    end
    Reset = 1'b0;
    step();
    checks++;
    if ({MemReq, Overrun, Busy, WbCount} !== 6'b0) begin
      errors++;
      $display("FAIL rst_mid: got Req=%b Ovr=%b Busy=%b Wb=%0d want 0 0 0 0",
               MemReq, Overrun, Busy, WbCount);
    end
    Reset = 1'b1;
    exp_q.delete();
    arch = phys;
    step();
  endtask

  task automatic test_random();
    bit ok;
    bit is_st;
    logic [W-1:0] a, d, e;
    rsp_en = 1; rsp_rand = 1; ack_budget = 1000000;
    for (int n = 0; n < 200; n++) begin
      for (int g = $urandom_range(0, 2); g > 0; g--) step();
      is_st = 1'($urandom_range(0, 1));
      a = 16'h0080 + 16'($urandom_range(0, 7));
      d = 16'($urandom);
      e = exp_load(a);
      if (is_st) do_store(a, d);
      else do_load(a);
      if (Busy === 1'b0) begin
        checks++;
        if (DataDone !== 1'b1 || (!is_st && DataIn !== e)) begin
          errors++;
          $display("FAIL rnd_fast: op=%0d addr=%h got Done=%b DataIn=%h want 1 %h",
                   is_st, a, DataDone, DataIn, e);
        end
      end else begin
        wait_done(200, ok);
        checks++;
        if (!ok || Busy !== 1'b0 || (!is_st && DataIn !== e)) begin
          errors++;
          $display("FAIL rnd_slow: op=%0d addr=%h got done=%b Busy=%b DataIn=%h want 1 0 %h",
                   is_st, a, ok, Busy, DataIn, e);
        end
      end
    end
    wait_drain("rnd");
    checks++;
    if (exp_q.size() != 0 || Overrun !== 1'b0) begin
      errors++;
      $display("FAIL rnd_end: got pending_writes=%0d Ovr=%b want 0 0", exp_q.size(), Overrun);
    end
  endtask

  initial begin
    test_reset();
    test_store_drain();
    test_forward();
    test_load_miss();
    test_full();
    test_overrun();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_port.md
Name: data_mem_port

Overview:
Data-side memory port that sits directly downstream of the processor's Memory1 stage. It consumes the processor's one-cycle data request (DataAddr/ReadData/WriteData/DataOut) and produces DataIn/DataDone for the Memory2 latch. Stores are posted into a small write buffer, so they complete without waiting on the bus. Loads are forwarded from the buffer on an address hit; otherwise they go to a variable-latency req/ack memory bus after the buffer has drained.

Parameters:
WORD_SIZE  16  data and address width
WB_DEPTH   4   write-buffer entries; power of 2, at least 2

Ports:
Clock      in   1                       rising-edge clock
Reset      in   1                       active-low, synchronous reset
DataAddr   in   WORD_SIZE               processor request address
DataOut    in   WORD_SIZE               processor store data
ReadData   in   1                       load request, valid for one cycle
WriteData  in   1                       store request, valid for one cycle
DataIn     out  WORD_SIZE               load result, registered
DataDone   out  1                       one-cycle pulse when a request completes
Busy       out  1                       request outstanding; processor must not issue
Overrun    out  1                       sticky: a request arrived while Busy was high
WbCount    out  $clog2(WB_DEPTH)+1      current write-buffer occupancy
MemReq     out  1                       bus request
MemWe      out  1                       bus write enable (1 = write)
MemAddr    out  WORD_SIZE               bus address
MemWData   out  WORD_SIZE               bus write data
MemAck     in   1                       bus completion; sampled only while MemReq=1
MemRData   in   WORD_SIZE               bus read data; valid with MemAck on a read

Behaviour:
Reset and outputs
- One clock with synchronous, active-low reset: Reset=0 sampled on a rising Clock edge clears all state.
- Reset values: all outputs 0, write buffer empty, FSM in B_IDLE, pending request cleared, Overrun cleared.
- A reset taken mid-bus-transaction drops MemReq at that edge. The in-flight transaction is abandoned.
- All outputs are registered.

Request acceptance
- A request is accepted at edge T when (ReadData | WriteData) and Busy=0.
- If both ReadData and WriteData are high, it is a store; the read is ignored.
- If a request arrives while Busy=1, it is dropped and Overrun is set to 1 until reset.

Stores
- Buffer not full at T: push {DataAddr, DataOut} at T. DataDone=1 during cycle T+1. Busy stays 0.
- Buffer full at T: latch the store as pending and set Busy=1 from T+1.
  - The pending store is pushed on the edge after the pop that frees a slot.
  - DataDone pulses in the cycle after the push, and Busy drops in that same cycle.

Loads
- The buffer is compared against DataAddr at T. Only entries present before T count.
- Hit: the youngest matching entry's data appears on DataIn in T+1, with DataDone=1 in T+1. Busy=0 and no bus read is issued.
- Miss: latch the load as pending and set Busy=1 from T+1.
  - The bus read is issued only after the buffer is empty, which preserves memory ordering.
  - On MemAck, MemRData is registered into DataIn. DataDone=1 in the next cycle, and Busy drops in that same cycle.
- DataIn holds its last value when DataDone=0.

Bus FSM (states B_IDLE, B_WRITE, B_READ)
- B_IDLE:
  - If the buffer is non-empty, go to B_WRITE: MemReq=1, MemWe=1, MemAddr/MemWData = head entry.
  - Otherwise, if a load is pending, go to B_READ: MemReq=1, MemWe=0, MemAddr = pending address.
  - Writes have priority over reads.
- B_WRITE: hold MemReq and all bus outputs stable until MemAck. On MemAck, pop the head, drop MemReq, go to B_IDLE.
- B_READ: hold until MemAck. On MemAck, drop MemReq, capture MemRData, clear pending, go to B_IDLE.
- Minimum inter-transaction gap: one idle cycle with MemReq=0.
- A push and a pop may happen on the same edge; WbCount then stays unchanged.

Buffer and arithmetic
- The buffer is a circular FIFO. Head and tail pointers wrap modulo WB_DEPTH.
- WbCount ranges 0..WB_DEPTH. Full when WbCount=WB_DEPTH, empty when WbCount=0.
- Address compare is exact over the full WORD_SIZE bits. There is no byte masking.

Test Plan:
1. Hold Reset=0 for 2 edges while inputs toggle -> all outputs 0, WbCount=0. Release, then wait 5 idle cycles -> MemReq stays 0.
2. Store addr 0x0010 data 0xBEEF at T, MemAck returned 2 cycles after MemReq rises -> DataDone=1 at T+1 with Busy=0. MemReq rises at T+1 with MemWe=1, MemAddr=0x0010, MemWData=0xBEEF. WbCount goes 1->0 after the ack.
3. Hold MemAck=0. Store 0x0020=0x1111, then store 0x0020=0x2222, then load 0x0020 -> DataIn=0x2222 with DataDone the cycle after the load. No MemWe=0 transaction occurs.
4. Two stores pending, then a load from 0x0030; bus returns 0x5A5A three cycles after the read request -> the two writes drain in order, then the read is issued. Busy=1 from load+1 until DataDone. DataIn=0x5A5A.
5. Hold MemAck=0 and issue 4 stores, then a 5th store to 0x0044=0x0005 -> WbCount=4 and Busy=1. Release MemAck for one pop -> the 5th store is pushed, DataDone pulses once, Busy=0, WbCount=4.
6. Issue a load request while Busy=1 -> the request is ignored and Overrun=1. Then drive Reset=0 while MemReq=1 -> MemReq=0 and Overrun=0 at the next edge.
